// File: rtl/scroll_message_engine_if.sv
// scroll_message_engine_if: write port, scroll controls and window outputs of the scroll engine
// master: message source / controller (drives writes and controls)
// slave:  scroll engine (drives wr_ready, seg_window, busy, step, wrap, msg_len)
interface scroll_message_engine_if #(
  parameter int MAX_LEN = 16
);
  logic wr_valid;
  logic [4:0] wr_char;
  logic wr_ready;
  logic start;
  logic stop;
  logic pause;
  logic clear;
  logic [31:0] seg_window;
  logic busy;
  logic step;
  logic wrap;
  logic [$clog2(MAX_LEN+1)-1:0] msg_len;
  modport master (
    output wr_valid, wr_char, start, stop, pause, clear,
    input wr_ready, seg_window, busy, step, wrap, msg_len
  );
  modport slave (
    input wr_valid, wr_char, start, stop, pause, clear,
    output wr_ready, seg_window, busy, step, wrap, msg_len
  );
endinterface

// File: rtl/scroll_message_engine.sv
// scroll_message_engine: buffers a character message and scrolls a 4-digit 7-segment window through it
// fastclk/reset: clock and synchronous active-high reset
// bus.wr_*: valid/ready character write; bus.start/stop/clear pulses, bus.pause level
// bus.seg_window: registered 4x8 segment codes, leftmost digit in [31:24]
// bus.busy/step/wrap/msg_len: scroll state, advance pulse, wrap-to-0 pulse, character count
module scroll_message_engine #(
  parameter int MAX_LEN = 16,
  parameter int STEP_TICKS = 200_000_000
) (
  input logic fastclk,
  input logic reset,
  scroll_message_engine_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int IW = LW + 1;
  localparam int TW = $clog2(STEP_TICKS);
  typedef enum logic {IDLE, SCROLL} state_t;
  state_t state, state_n;
  logic [LW-1:0] len, len_n, pos, pos_n;
  logic [TW-1:0] tick, tick_n;
  logic [4:0] mem [MAX_LEN];
  logic [31:0] win_n;
  logic [IW-1:0] idx;
  logic [4:0] code;
  logic we, step_n, wrap_n;

  function automatic logic [7:0] enc(input logic [4:0] c);
    case (c)
      5'h00: enc = 8'hFC;
      5'h01: enc = 8'h60;
      5'h02: enc = 8'hDA;
      5'h03: enc = 8'hF2;
      5'h04: enc = 8'h66;
      5'h05: enc = 8'hB6;
      5'h06: enc = 8'hBE;
      5'h07: enc = 8'hE0;
      5'h08: enc = 8'hFE;
      5'h09: enc = 8'hF6;
      5'h11: enc = 8'h7A;
      5'h12: enc = 8'h1C;
      5'h13: enc = 8'h02;
      default: enc = 8'h00;
    endcase
  endfunction

  assign bus.wr_ready = state == IDLE && len < LW'(MAX_LEN);
  assign bus.busy = state == SCROLL;
  assign bus.msg_len = len;

  // start sees the post-write length, so a write plus start on an empty buffer scrolls
  always_comb begin
    state_n = state;
    len_n = len;
    pos_n = pos;
    tick_n = tick;
    we = 1'b0;
    step_n = 1'b0;
    wrap_n = 1'b0;
    if (bus.clear) begin
      state_n = IDLE;
      len_n = '0;
      pos_n = '0;
      tick_n = '0;
    end else if (state == SCROLL) begin
      if (bus.stop) begin
        state_n = IDLE;
        pos_n = '0;
        tick_n = '0;
      end else if (!bus.pause && tick != TW'(STEP_TICKS - 1)) begin
        tick_n = tick + 1'b1;
      end else if (!bus.pause) begin
        tick_n = '0;
        pos_n = (pos + 1'b1 == len) ? '0 : pos + 1'b1;
        step_n = 1'b1;
        wrap_n = pos + 1'b1 == len;
      end
    end else begin
      we = bus.wr_valid && bus.wr_ready;
      len_n = len + LW'(we);
      if (bus.start && !bus.stop && len_n != '0) begin
        state_n = SCROLL;
        pos_n = '0;
        tick_n = '0;
      end
    end
  end

  // (pos+k) mod len by repeated subtraction: pos < len and k <= 3, so three passes cover len = 1
  always_comb begin
    win_n = '0;
    idx = '0;
    code = '0;
    for (int k = 0; k < 4; k++) begin
      idx = (state == SCROLL) ? IW'(pos) + IW'(k) : IW'(k);
      for (int s = 0; s < 3; s++) idx = (state == SCROLL && idx >= IW'(len)) ? idx - IW'(len) : idx;
      code = (state == SCROLL || idx < IW'(len)) ? mem[idx[AW-1:0]] : 5'h10;
      win_n[31-8*k -: 8] = enc(code);
    end
  end

  always_ff @(posedge fastclk) begin
    if (reset) begin
      state <= IDLE;
      len <= '0;
      pos <= '0;
      tick <= '0;
      bus.seg_window <= '0;
      bus.step <= 1'b0;
      bus.wrap <= 1'b0;
    end else begin
      state <= state_n;
      len <= len_n;
      pos <= pos_n;
      tick <= tick_n;
      bus.seg_window <= win_n;
      bus.step <= step_n;
      bus.wrap <= wrap_n;
    end
  end

  always_ff @(posedge fastclk) if (we && !reset) mem[len[AW-1:0]] <= bus.wr_char;
endmodule

// File: tb/tb_scroll_message_engine.sv
// tb_scroll_message_engine: scoreboard bench comparing the scroll engine against a queue-based message model
module tb_scroll_message_engine;
  localparam int MAXL = 8;
  localparam int ST = 4;
  localparam int LW = $clog2(MAXL + 1);
  typedef struct packed {
    logic [31:0] win;
    logic busy;
    logic step;
    logic wrap;
    logic rdy;
    logic [LW-1:0] len;
  } exp_t;

  logic fastclk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t x;
  bit m_scroll;
  logic [4:0] m_msg[$];
  int m_pos, m_tick;
  logic [7:0] tab [20] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6,
                           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7A, 8'h1C, 8'h02};

  scroll_message_engine_if #(.MAX_LEN(MAXL)) bus ();
  scroll_message_engine #(.MAX_LEN(MAXL), .STEP_TICKS(ST)) dut (.fastclk(fastclk), .reset(reset), .bus(bus));

  always #5 fastclk = ~fastclk;

  function automatic logic [7:0] seg(input logic [4:0] c);
    return (c < 5'd20) ? tab[c] : 8'h00;
  endfunction

  function automatic logic [31:0] mwin();
    logic [31:0] w;
    logic [4:0] c;
    int n;
    w = '0;
    n = m_msg.size();
    for (int k = 0; k < 4; k++) begin
      c = 5'h10;
      if (m_scroll) c = m_msg[(m_pos + k) % n];
      else if (k < n) c = m_msg[k];
      w[31-8*k -: 8] = seg(c);
    end
    return w;
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [4:0] c, input bit s, input bit sp, input bit pz, input bit cl);
    exp_t e;
    @(negedge fastclk);
    reset = r;
    bus.wr_valid = v;
    bus.wr_char = c;
    bus.start = s;
    bus.stop = sp;
    bus.pause = pz;
    bus.clear = cl;
    e = '0;
    if (r) begin
      m_scroll = 0;
      m_msg.delete();
      m_pos = 0;
      m_tick = 0;
    end else begin
      e.win = mwin();
      if (cl) begin
        m_scroll = 0;
        m_msg.delete();
        m_pos = 0;
        m_tick = 0;
      end else if (m_scroll) begin
        if (sp) begin
          m_scroll = 0;
          m_pos = 0;
          m_tick = 0;
        end else if (!pz) begin
          m_tick++;
          if (m_tick == ST) begin
            m_tick = 0;
            m_pos = (m_pos + 1) % m_msg.size();
            e.step = 1'b1;
            e.wrap = m_pos == 0;
          end
        end
      end else begin
        if (v && m_msg.size() < MAXL) m_msg.push_back(c);
        if (s && !sp && m_msg.size() > 0) begin
          m_scroll = 1;
          m_pos = 0;
          m_tick = 0;
        end
      end
    end
    e.busy = m_scroll;
    e.len = LW'(m_msg.size());
    e.rdy = !m_scroll && m_msg.size() < MAXL;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 5'($urandom), 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [4:0] c);
    cyc(0, 1, c, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  always @(posedge fastclk) begin
    #1;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      chk("seg_window", bus.seg_window, x.win);
      chk("busy", 32'(bus.busy), 32'(x.busy));
      chk("step", 32'(bus.step), 32'(x.step));
      chk("wrap", 32'(bus.wrap), 32'(x.wrap));
      chk("wr_ready", 32'(bus.wr_ready), 32'(x.rdy));
      chk("msg_len", 32'(bus.msg_len), 32'(x.len));
    end
  end

  initial begin
    bit pz;
    bus.wr_valid = 0;
    bus.wr_char = 0;
    bus.start = 0;
    bus.stop = 0;
    bus.pause = 0;
    bus.clear = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    wr(2); wr(0); wr(1); wr(9);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    wr(2); wr(0); wr(1); wr(9); wr(5'h10); wr(5'h10);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(30);
    for (int i = 0; i < 6; i++) cyc(0, 1, 5'($urandom), 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    idle(9);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(10);
    cyc(0, 0, 0, 1, 0, 0, 1);
    idle(3);
    wr(8);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(14);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < MAXL + 2; i++) wr(5'(i % 20));
    idle(2);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(7);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 1, 5'h11, 1, 0, 0, 0);
    idle(10);
    cyc(0, 0, 0, 0, 0, 0, 1);
    pz = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) pz = !pz;
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 21)),
          $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0, pz, $urandom_range(0, 149) == 0);
    end
    idle(2);
    @(posedge fastclk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
